// File: rtl/tstate_sequencer_if.sv
// rtl/tstate_sequencer_if.sv - T-state sequencer signal bundle
interface tstate_sequencer_if #(
    parameter int OPW  = 8,
    parameter int CNTW = 16
);
    logic [2:0]      T;
    logic [15:0]     bus_in;
    logic            uend;
    logic            halt_req;
    logic            fetch_ar;
    logic            fetch_ir;
    logic            pc_inc;
    logic            exec;
    logic [OPW+2:0]  uaddr;
    logic [OPW-1:0]  ir;
    logic            treset;
    logic            halted;
    logic [CNTW-1:0] retired;

    modport master (
        output T, bus_in, uend, halt_req,
        input  fetch_ar, fetch_ir, pc_inc, exec, uaddr, ir, treset, halted, retired
    );

    modport slave (
        input  T, bus_in, uend, halt_req,
        output fetch_ar, fetch_ir, pc_inc, exec, uaddr, ir, treset, halted, retired
    );
endinterface

// File: rtl/tstate_sequencer.sv
// rtl/tstate_sequencer.sv - fetch/execute decode, opcode latch, early-end and halt control
module tstate_sequencer #(
    parameter int OPW  = 8,
    parameter int CNTW = 16
) (
    input  logic              clk,
    input  logic              reset,
    tstate_sequencer_if.slave sif
);
    typedef enum logic {RUN, HALTED} state_t;

    state_t          state;
    logic [OPW-1:0]  ir_q;
    logic            treset_q;
    logic [CNTW-1:0] retired_q;

    logic run;
    logic in_exec;
    logic end_evt;
    logic unused_bus;

    assign run     = (state == RUN);
    assign in_exec = (sif.T >= 3'd2);
    // T7 ends the instruction even without uend: the counter wraps on its own.
    assign end_evt = run && in_exec && (sif.uend || (sif.T == 3'd7));

    assign unused_bus = ^sif.bus_in[15-OPW:0];

    assign sif.fetch_ar = run && (sif.T == 3'd0);
    assign sif.fetch_ir = run && (sif.T == 3'd1);
    assign sif.pc_inc   = run && (sif.T == 3'd1);
    assign sif.exec     = run && in_exec;
    assign sif.uaddr    = {ir_q, sif.T};
    assign sif.ir       = ir_q;
    assign sif.treset   = treset_q;
    assign sif.halted   = (state == HALTED);
    assign sif.retired  = retired_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            ir_q      <= '0;
            treset_q  <= 1'b1;
            retired_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    treset_q <= 1'b0;
                    if (sif.T == 3'd1)
                        ir_q <= sif.bus_in[15:16-OPW];
                    if (end_evt) begin
                        retired_q <= retired_q + CNTW'(1);
                        if (sif.halt_req) begin
                            state    <= HALTED;
                            treset_q <= 1'b1;
                        end else if (sif.T != 3'd7) begin
                            // Early end: pull the counter back to T0 for one edge.
                            treset_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    treset_q <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    treset_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tstate_sequencer.sv
// tb/tb_tstate_sequencer.sv - self-checking bench for tstate_sequencer
module tb_tstate_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;

    tstate_sequencer_if #(.OPW(8), .CNTW(16)) ifc ();

    tstate_sequencer #(.OPW(8), .CNTW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .sif   (ifc.slave)
    );

    always #5 clk = ~clk;

    // T-state counter the sequencer drives: falling-edge advance, async clear.
    logic [2:0] t_cnt = 3'd0;
    logic [2:0] t_man = 3'd0;
    bit         manual = 1'b0;

    always @(negedge clk or posedge reset or posedge ifc.treset)
        if (reset || ifc.treset) t_cnt <= 3'd0;
        else                     t_cnt <= t_cnt + 3'd1;

    assign ifc.T = manual ? t_man : t_cnt;

    int          checks = 0;
    int          fails  = 0;
    logic [7:0]  exp_ir = 8'h00;
    logic [15:0] exp_ret = 16'h0000;
    bit          exp_halted = 1'b0;

    // One instruction at instruction level: opcode, step on which it ends, halt request.
    task automatic run_instr(input logic [7:0] op, input int end_t, input bit uend_end,
                             input bit hreq, input bit rnd);
        int         k;
        bit         done;
        bit         exp_tr;
        logic [2:0] t;
        k = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk); #1;
            t = ifc.T;
            checks++;
            if (t !== 3'(k)) begin
                fails++;
                $display("FAIL tseq op=%h step %0d: T=%0d required %0d", op, k, t, k);
            end
            if (t == 3'd1) ifc.bus_in = rnd ? {op, 8'($urandom)} : {op, 8'h00};
            else           ifc.bus_in = rnd ? 16'($urandom) : 16'h0000;
            if (int'(t) == end_t) ifc.uend = uend_end;
            else if (t < 3'd2)    ifc.uend = rnd ? 1'($urandom) : 1'b0;
            else                  ifc.uend = 1'b0;
            ifc.halt_req = (int'(t) == end_t) ? hreq : (rnd ? 1'($urandom) : 1'b0);
            #1;
            checks++;
            if ({ifc.fetch_ar, ifc.fetch_ir, ifc.pc_inc, ifc.exec} !==
                {t == 3'd0, t == 3'd1, t == 3'd1, t >= 3'd2}) begin
                fails++;
                $display("FAIL decode T=%0d: ar/ir/pc/exec=%b required %b", t,
                         {ifc.fetch_ar, ifc.fetch_ir, ifc.pc_inc, ifc.exec},
                         {t == 3'd0, t == 3'd1, t == 3'd1, t >= 3'd2});
            end
            checks++;
            if (ifc.uaddr !== {exp_ir, t}) begin
                fails++;
                $display("FAIL uaddr T=%0d: %h required %h", t, ifc.uaddr, {exp_ir, t});
            end
            @(posedge clk); #1;
            if (t == 3'd1) exp_ir = op;
            if (int'(t) == end_t) begin
                exp_ret = exp_ret + 16'd1;
                if (hreq) exp_halted = 1'b1;
                done = 1'b1;
            end
            exp_tr = exp_halted || ((int'(t) == end_t) && (end_t != 7));
            checks++;
            if (ifc.ir !== exp_ir) begin
                fails++;
                $display("FAIL ir T=%0d: %h required %h", t, ifc.ir, exp_ir);
            end
            checks++;
            if (ifc.retired !== exp_ret) begin
                fails++;
                $display("FAIL retired T=%0d: %h required %h", t, ifc.retired, exp_ret);
            end
            checks++;
            if (ifc.treset !== exp_tr) begin
                fails++;
                $display("FAIL treset T=%0d: %b required %b", t, ifc.treset, exp_tr);
            end
            checks++;
            if (ifc.halted !== exp_halted) begin
                fails++;
                $display("FAIL halted T=%0d: %b required %b", t, ifc.halted, exp_halted);
            end
            k++;
            if (!done && k > 9) begin
                checks++;
                fails++;
                $display("FAIL timeout op=%h: no end event within %0d clocks, required end at T=%0d", op, k, end_t);
                done = 1'b1;
            end
        end
    endtask

    // Called at posedge+1; leaves the bench at posedge+1 with reset released.
    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ir = 8'h00;
        exp_ret = 16'h0000;
        exp_halted = 1'b0;
    endtask

    task automatic test_reset();
        ifc.bus_in = 16'h0000;
        ifc.uend = 1'b0;
        ifc.halt_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({ifc.ir, ifc.retired, ifc.halted} !== 25'h0) begin
            fails++;
            $display("FAIL reset_regs: ir=%h retired=%h halted=%b required zero", ifc.ir, ifc.retired, ifc.halted);
        end
        checks++;
        if (ifc.treset !== 1'b1) begin
            fails++;
            $display("FAIL reset_treset: %b required 1", ifc.treset);
        end
        checks++;
        if (ifc.fetch_ar !== 1'b1 || ifc.exec !== 1'b0) begin
            fails++;
            $display("FAIL reset_decode: fetch_ar=%b exec=%b required 1 0", ifc.fetch_ar, ifc.exec);
        end
        reset = 1'b0;
    endtask

    task automatic test_full_instr();
        run_instr(8'hA5, 7, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ifc.ir !== 8'hA5 || ifc.retired !== 16'd1) begin
            fails++;
            $display("FAIL full_instr: ir=%h retired=%h required a5 0001", ifc.ir, ifc.retired);
        end
    endtask

    task automatic test_early_end();
        logic [7:0] op2;
        run_instr(8'h3C, 3, 1'b1, 1'b0, 1'b0);
        op2 = 8'($urandom) ^ 8'h3C;
        run_instr(op2, 7, 1'b0, 1'b0, 1'b0);
        checks++;
        if (ifc.ir !== op2) begin
            fails++;
            $display("FAIL early_next_ir: %h required %h", ifc.ir, op2);
        end
    endtask

    task automatic test_uend_t7();
        run_instr(8'h5A, 7, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        int e;
        for (int i = 0; i < 40; i++) begin
            e = $urandom_range(2, 7);
            run_instr(8'($urandom), e, (e < 7) ? 1'b1 : 1'($urandom), 1'b0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        int n;
        n = 65535 - int'(exp_ret);
        t_man = 3'd2;
        ifc.uend = 1'b1;
        ifc.halt_req = 1'b0;
        manual = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        checks++;
        if (ifc.retired !== 16'hFFFF) begin
            fails++;
            $display("FAIL wrap_max: retired=%h required ffff", ifc.retired);
        end
        @(posedge clk); #1;
        checks++;
        if (ifc.retired !== 16'h0000) begin
            fails++;
            $display("FAIL wrap_zero: retired=%h required 0000", ifc.retired);
        end
        exp_ret = 16'h0000;
        ifc.uend = 1'b0;
        manual = 1'b0;
    endtask

    task automatic test_midop_reset();
        int guard;
        run_instr(8'h77, 2, 1'b1, 1'b0, 1'b0);
        run_instr(8'h81, 5, 1'b1, 1'b0, 1'b0);
        ifc.uend = 1'b0;
        guard = 0;
        do begin
            @(negedge clk); #1;
            if (ifc.T == 3'd1) ifc.bus_in = 16'hC3FF;
            guard++;
        end while (ifc.T != 3'd5 && guard < 12);
        checks++;
        if (ifc.T != 3'd5) begin
            fails++;
            $display("FAIL midop_reach: T=%0d required 5", ifc.T);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({ifc.ir, ifc.retired, ifc.treset, ifc.halted} !== 26'b10) begin
            fails++;
            $display("FAIL midop_reset: ir=%h retired=%h treset=%b halted=%b required 00 0000 1 0",
                     ifc.ir, ifc.retired, ifc.treset, ifc.halted);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        exp_ir = 8'h00;
        exp_ret = 16'h0000;
        exp_halted = 1'b0;
        run_instr(8'h19, 7, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_halt();
        run_instr(8'hE1, 4, 1'b1, 1'b1, 1'b0);
        manual = 1'b1;
        for (int i = 0; i < 10; i++) begin
            t_man = 3'($urandom);
            ifc.bus_in = 16'($urandom);
            ifc.uend = 1'($urandom);
            ifc.halt_req = 1'($urandom);
            #1;
            checks++;
            if ({ifc.fetch_ar, ifc.fetch_ir, ifc.pc_inc, ifc.exec} !== 4'b0000) begin
                fails++;
                $display("FAIL halt_decode T=%0d: %b required 0000", t_man,
                         {ifc.fetch_ar, ifc.fetch_ir, ifc.pc_inc, ifc.exec});
            end
            @(posedge clk); #1;
            checks++;
            if (ifc.treset !== 1'b1 || ifc.halted !== 1'b1 || ifc.ir !== exp_ir || ifc.retired !== exp_ret) begin
                fails++;
                $display("FAIL halt_hold: treset=%b halted=%b ir=%h retired=%h required 1 1 %h %h",
                         ifc.treset, ifc.halted, ifc.ir, ifc.retired, exp_ir, exp_ret);
            end
        end
        manual = 1'b0;
        do_reset();
        checks++;
        if (ifc.halted !== 1'b0 || ifc.treset !== 1'b1) begin
            fails++;
            $display("FAIL halt_exit: halted=%b treset=%b required 0 1", ifc.halted, ifc.treset);
        end
        run_instr(8'h42, 6, 1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_full_instr();
        test_early_end();
        test_uend_t7();
        test_random();
        test_wrap();
        test_midop_reset();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
